// File: rtl/wb_pkg.sv
// Shared writeback-path types: register address/data widths and the queued entry layout.
package wb_pkg;

    localparam int REG_AW = 3;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [REG_AW-1:0] adr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the live region of the writeback queue for one read address.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                   entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]    head_i,
    input  logic [$clog2(DEPTH):0]      count_i,
    input  logic [REG_AW-1:0]           adr_i,
    output logic                        hit_o,
    output logic [DATA_W-1:0]           data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = head_i;
        // Walk oldest to youngest so the last live match wins; register 0 never forwards.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if ((CW'(k) < count_i) && (adr_i != '0) && (entries_i[idx].adr == adr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue between producers and the register file, with optional read forwarding.
// Forwarding is built only when WB_QUEUE_FWD_EN is defined; otherwise fwd_* outputs are tied low.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_AW-1:0]       in_adr,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    rf_ready,
    output logic                    RegWrite,
    output logic [REG_AW-1:0]       WrAdr,
    output logic [DATA_W-1:0]       WrData,
    input  logic [REG_AW-1:0]       adr1,
    input  logic [REG_AW-1:0]       adr2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [DATA_W-1:0]       fwd_data1,
    output logic [DATA_W-1:0]       fwd_data2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    wb_entry_t     head_entry;

    // in_ready depends on registered count only, so rf_ready never reaches the producer.
    assign in_ready   = (count_q < CW'(DEPTH));
    assign push       = in_valid && in_ready && (in_adr != '0);
    assign RegWrite   = (count_q != '0) && rf_ready;
    assign pop        = RegWrite;
    assign head_entry = (count_q != '0) ? mem_q[head_q] : '0;
    assign WrAdr      = head_entry.adr;
    assign WrData     = head_entry.data;
    assign count      = count_q;

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; count and head decide which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{adr: in_adr, data: in_data};
        end
    end

`ifdef WB_QUEUE_FWD_EN
    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .adr_i     (adr1),
        .hit_o     (fwd_hit1),
        .data_o    (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .adr_i     (adr2),
        .hit_o     (fwd_hit2),
        .data_o    (fwd_data2)
    );
`else
    logic unused_fwd_adr;

    assign unused_fwd_adr = ^{adr1, adr2};
    assign fwd_hit1       = 1'b0;
    assign fwd_hit2       = 1'b0;
    assign fwd_data1      = '0;
    assign fwd_data2      = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: drain latency, full handling, wrap-around, forwarding, reg-0 discard, reset.
module tb_wb_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef WB_QUEUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_adr;
    logic [DATA_W-1:0] in_data;
    logic              rf_ready;
    logic              RegWrite;
    logic [REG_AW-1:0] WrAdr;
    logic [DATA_W-1:0] WrData;
    logic [REG_AW-1:0] adr1;
    logic [REG_AW-1:0] adr2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
    logic [2:0]        count;

    int n_cmp = 0;
    int n_err = 0;
    int p;
    int q;
    int exp_cnt;

    logic [2:0] t2_adr [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [7:0] t2_dat [4] = '{8'hA1, 8'hA2, 8'hA5, 8'hA7};

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_adr    (in_adr),
        .in_data   (in_data),
        .rf_ready  (rf_ready),
        .RegWrite  (RegWrite),
        .WrAdr     (WrAdr),
        .WrData    (WrData),
        .adr1      (adr1),
        .adr2      (adr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] a, input logic [7:0] d);
        in_valid = v;
        in_adr   = a;
        in_data  = d;
    endtask

    function automatic logic [2:0] item_adr(input int k);
        return 3'((k % 7) + 1);
    endfunction

    function automatic logic [7:0] item_dat(input int k);
        return 8'(8'h30 + k);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_regwrite"}, RegWrite, 0);
        check({tag, "_wradr"}, WrAdr, 0);
        check({tag, "_wrdata"}, WrData, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_hit1"}, fwd_hit1, 0);
        check({tag, "_hit2"}, fwd_hit2, 0);
        check({tag, "_data1"}, fwd_data1, 0);
        check({tag, "_data2"}, fwd_data2, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0);
        rf_ready = 1'b1;
        adr1 = 3'd0;
        adr2 = 3'd0;
        #1 rst = 1'b1;
        #2;
        check_idle("rst_during");
        #9 rst = 1'b0;
        tick;
        check_idle("rst_after");

        // Single entry: visible the cycle after its push edge, then popped.
        drive(1, 3'd3, 8'h5A);
        settle;
        check("t1_pre_count", count, 0);
        check("t1_pre_regwrite", RegWrite, 0);
        tick;
        drive(0, 0, 0);
        settle;
        check("t1_count", count, 1);
        check("t1_regwrite", RegWrite, 1);
        check("t1_wradr", WrAdr, 3);
        check("t1_wrdata", WrData, 8'h5A);
        tick;
        settle;
        check("t1_drained_count", count, 0);
        check("t1_drained_regwrite", RegWrite, 0);
        check("t1_drained_wrdata", WrData, 0);

        // Fill while the register file stalls; a fifth request must not be taken.
        rf_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, t2_adr[i], t2_dat[i]);
            settle;
            check("t2_fill_ready", in_ready, 1);
            tick;
        end
        drive(1, 3'd6, 8'hEE);
        settle;
        check("t2_full_count", count, 4);
        check("t2_full_ready", in_ready, 0);
        check("t2_full_regwrite", RegWrite, 0);
        tick;
        drive(0, 0, 0);
        settle;
        check("t2_5th_ignored", count, 4);
        rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle;
            check("t2_drain_regwrite", RegWrite, 1);
            check("t2_drain_wradr", WrAdr, t2_adr[i]);
            check("t2_drain_wrdata", WrData, t2_dat[i]);
            check("t2_drain_count", count, 4 - i);
            tick;
        end
        settle;
        check("t2_empty_count", count, 0);
        check("t2_empty_regwrite", RegWrite, 0);

        // Stream 10 entries through a full queue with the producer holding valid.
        rf_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1, item_adr(k), item_dat(k));
            tick;
        end
        drive(0, 0, 0);
        settle;
        check("t3_full_count", count, 4);
        check("t3_full_ready", in_ready, 0);
        p = 4;
        q = 0;
        rf_ready = 1'b1;
        for (int cyc = 0; cyc < 24 && q < 10; cyc++) begin
            exp_cnt = p - q;
            drive(p < 10, item_adr(p), item_dat(p));
            settle;
            check("t3_count", count, exp_cnt);
            check("t3_in_ready", in_ready, exp_cnt < 4);
            check("t3_regwrite", RegWrite, 1);
            check("t3_wradr", WrAdr, item_adr(q));
            check("t3_wrdata", WrData, item_dat(q));
            if (p < 10 && exp_cnt < 4) p++;
            q++;
            tick;
        end
        drive(0, 0, 0);
        settle;
        check("t3_drained", count, 0);

        // Forwarding: youngest of two writes to r2 wins; a same-cycle push is invisible.
        rf_ready = 1'b0;
        adr1 = 3'd2;
        adr2 = 3'd3;
        drive(1, 3'd2, 8'h11);
        settle;
        check("t4_push_invisible_hit", fwd_hit1, 0);
        check("t4_push_invisible_data", fwd_data1, 0);
        tick;
        drive(1, 3'd2, 8'h22);
        settle;
        check("t4_one_hit", fwd_hit1, FWD);
        check("t4_one_data", fwd_data1, FWD ? 8'h11 : 8'h00);
        tick;
        drive(0, 0, 0);
        settle;
        check("t4_young_hit", fwd_hit1, FWD);
        check("t4_young_data", fwd_data1, FWD ? 8'h22 : 8'h00);
        check("t4_miss_hit", fwd_hit2, 0);
        check("t4_miss_data", fwd_data2, 0);
        rf_ready = 1'b1;
        settle;
        check("t4_pop1_wrdata", WrData, 8'h11);
        check("t4_pop1_data", fwd_data1, FWD ? 8'h22 : 8'h00);
        tick;
        settle;
        check("t4_pop2_wrdata", WrData, 8'h22);
        check("t4_pop2_hit", fwd_hit1, FWD);
        check("t4_pop2_data", fwd_data1, FWD ? 8'h22 : 8'h00);
        tick;
        settle;
        check("t4_after_hit", fwd_hit1, 0);
        check("t4_after_data", fwd_data1, 0);
        check("t4_after_count", count, 0);

        // Writes to register 0 are accepted but dropped.
        rf_ready = 1'b0;
        adr1 = 3'd4;
        adr2 = 3'd0;
        drive(1, 3'd4, 8'h44);
        tick;
        drive(1, 3'd0, 8'hFF);
        settle;
        check("t5_r0_ready", in_ready, 1);
        tick;
        drive(0, 0, 0);
        settle;
        check("t5_r0_count", count, 1);
        check("t5_r0_hit2", fwd_hit2, 0);
        check("t5_r0_data2", fwd_data2, 0);
        check("t5_hit1", fwd_hit1, FWD);
        check("t5_data1", fwd_data1, FWD ? 8'h44 : 8'h00);
        rf_ready = 1'b1;
        settle;
        check("t5_wradr", WrAdr, 4);
        check("t5_wrdata", WrData, 8'h44);
        tick;
        settle;
        check("t5_empty_count", count, 0);
        check("t5_empty_regwrite", RegWrite, 0);

        // Asynchronous reset mid-drain discards everything before the next edge.
        rf_ready = 1'b0;
        adr1 = 3'd3;
        adr2 = 3'd0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 3'(k + 1), 8'(8'h61 + k));
            tick;
        end
        drive(0, 0, 0);
        rf_ready = 1'b1;
        tick;
        settle;
        check("t6_mid_count", count, 3);
        check("t6_mid_wradr", WrAdr, 2);
        rst = 1'b1;
        #1;
        check_idle("t6_rst");
        #1 rst = 1'b0;
        tick;
        check_idle("t6_after");
        drive(1, 3'd5, 8'h77);
        tick;
        drive(0, 0, 0);
        settle;
        check("t6_restart_count", count, 1);
        check("t6_restart_wradr", WrAdr, 5);
        check("t6_restart_wrdata", WrData, 8'h77);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
